// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port indices and access size.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int PORT_CORE = 0;
  localparam int PORT_DBG  = 1;
  localparam int DW_BYTES  = 8;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin picker: with both requesting, the port that did not win last time goes.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[PORT_CORE] && req[PORT_DBG]) begin
      if (last) gnt[PORT_CORE] = 1'b1;
      else      gnt[PORT_DBG]  = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port doubleword memory between the core LSU and the debug loader,
// one access at a time, with a bounds/alignment check ahead of any memory strobe.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int MEM_BYTES   = 64,
  parameter int ALIGN_CHECK = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [ADDR_W-1:0]   Mem_Addr,
  output logic [DATA_W-1:0]   Write_Data,
  output logic                MemWrite,
  output logic                MemRead,
  input  logic [DATA_W-1:0]   Read_Data
);

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - DW_BYTES);

  state_t              state;
  logic                last_grant;
  logic                lat_port;
  logic                lat_write;
  logic                lat_err;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  logic [1:0]          gnt;
  logic                hs;
  logic                sel_port;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_err;

  // Unsigned compare against the last legal doubleword start, so addresses near 2^ADDR_W never wrap into range.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a > MAX_ADDR) || ((ALIGN_CHECK != 0) && (a[2:0] != 3'b000));
  endfunction

  rr_arb2 u_arb (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (gnt)
  );

  assign req_ready = (state == IDLE) ? gnt : 2'b00;
  assign hs        = |(req_valid & req_ready);
  assign sel_port  = gnt[PORT_DBG];
  assign sel_addr  = sel_port ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
  assign sel_wdata = sel_port ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  assign sel_err   = addr_bad(sel_addr);

  // Request acceptance / FSM: errors bypass ACCESS so no strobe is ever raised for them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_port   <= 1'b0;
      lat_write  <= 1'b0;
      lat_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            last_grant <= sel_port;
            lat_port   <= sel_port;
            lat_write  <= req_write[sel_port];
            lat_err    <= sel_err;
            if (sel_err) begin
              rsp_rdata <= '0;
              state     <= RESP;
            end else begin
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          rsp_rdata <= lat_write ? '0 : Read_Data;
          state     <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && hs) begin
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
    end
  end

  // Memory drive / response: decoded from state so an async reset drops strobes at once.
  assign Mem_Addr   = (state == ACCESS) ? lat_addr  : '0;
  assign Write_Data = (state == ACCESS) ? lat_wdata : '0;
  assign MemWrite   = (state == ACCESS) &&  lat_write;
  assign MemRead    = (state == ACCESS) && !lat_write;
  assign rsp_valid  = (state == RESP) ? (lat_port ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_err    = (state == RESP) && lat_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: two instances (alignment check on/off) fed the same requests,
// each backed by its own byte-addressed 64-byte memory model.
module tb_dmem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_write;
  logic [127:0] req_addr;
  logic [127:0] req_wdata;

  logic [1:0]   req_ready, rsp_valid;
  logic         rsp_err, MemWrite, MemRead;
  logic [63:0]  rsp_rdata, Mem_Addr, Write_Data, Read_Data;

  logic [1:0]   req_ready_na, rsp_valid_na;
  logic         rsp_err_na, MemWrite_na, MemRead_na;
  logic [63:0]  rsp_rdata_na, Mem_Addr_na, Write_Data_na, Read_Data_na;

  logic [511:0] mem_a  = {384'd0, 64'd2, 64'd1};
  logic [511:0] mem_na = {384'd0, 64'd2, 64'd1};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_BYTES(64), .ALIGN_CHECK(1)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .Mem_Addr(Mem_Addr), .Write_Data(Write_Data), .MemWrite(MemWrite),
    .MemRead(MemRead), .Read_Data(Read_Data)
  );

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_BYTES(64), .ALIGN_CHECK(0)) u_dut_na (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_na),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_na), .rsp_err(rsp_err_na), .rsp_rdata(rsp_rdata_na),
    .Mem_Addr(Mem_Addr_na), .Write_Data(Write_Data_na), .MemWrite(MemWrite_na),
    .MemRead(MemRead_na), .Read_Data(Read_Data_na)
  );

  // Little-endian byte-addressed doubleword read; out-of-range reads return 0.
  function automatic logic [63:0] mem_rd(input logic [511:0] m, input logic [63:0] a);
    if (a > 64'd56) return 64'd0;
    return m[{a[5:0], 3'b000} +: 64];
  endfunction

  assign Read_Data    = mem_rd(mem_a, Mem_Addr);
  assign Read_Data_na = mem_rd(mem_na, Mem_Addr_na);

  always @(posedge clk) begin
    if (MemWrite && Mem_Addr <= 64'd56)
      mem_a[{Mem_Addr[5:0], 3'b000} +: 64] <= Write_Data;
    if (MemWrite_na && Mem_Addr_na <= 64'd56)
      mem_na[{Mem_Addr_na[5:0], 3'b000} +: 64] <= Write_Data_na;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic w, input logic [63:0] a, input logic [63:0] d);
    req_valid[p]         = 1'b1;
    req_write[p]         = w;
    req_addr[p*64 +: 64]  = a;
    req_wdata[p*64 +: 64] = d;
  endtask

  task automatic clr_req();
    req_valid = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    total++;
    if ({req_ready, rsp_valid, rsp_err, MemRead, MemWrite} !== 7'd0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0", {req_ready, rsp_valid, rsp_err, MemRead, MemWrite});
    end
    total++;
    if ({Mem_Addr, Write_Data, rsp_rdata} !== 192'd0) begin
      bad++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want all 0", Mem_Addr, Write_Data, rsp_rdata);
    end
    tick();
    reset = 1'b0;
    #3;
    total++;
    if ({req_ready, rsp_valid, MemRead, MemWrite} !== 6'd0) begin
      bad++; $display("FAIL reset_idle: got %b want 0", {req_ready, rsp_valid, MemRead, MemWrite});
    end
    tick();
  endtask

  task automatic test_load();
    set_req(0, 1'b0, 64'd8, 64'd0);
    #3;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL load_ready: got %b want 01", req_ready); end
    tick();
    clr_req();
    total++;
    if ({MemRead, MemWrite, Mem_Addr} !== {2'b10, 64'd8}) begin
      bad++; $display("FAIL load_strobe: rd=%b wr=%b addr=%0d want rd=1 wr=0 addr=8", MemRead, MemWrite, Mem_Addr);
    end
    tick();
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b0, 64'd2}) begin
      bad++; $display("FAIL load_rsp: valid=%b err=%b rdata=%h want 01 0 2", rsp_valid, rsp_err, rsp_rdata);
    end
    tick();
    total++;
    if ({rsp_valid, rsp_rdata} !== {2'b00, 64'd2}) begin
      bad++; $display("FAIL load_hold: valid=%b rdata=%h want 00 2", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_store_load();
    set_req(1, 1'b1, 64'd16, 64'hDEADBEEF_00C0FFEE);
    #3;
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("FAIL store_ready: got %b want 10", req_ready); end
    tick();
    clr_req();
    total++;
    if ({MemWrite, MemRead, Mem_Addr, Write_Data} !== {2'b10, 64'd16, 64'hDEADBEEF_00C0FFEE}) begin
      bad++; $display("FAIL store_strobe: wr=%b rd=%b addr=%0d wdata=%h", MemWrite, MemRead, Mem_Addr, Write_Data);
    end
    tick();
    total++;
    if ({MemWrite, rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 2'b10, 1'b0, 64'd0}) begin
      bad++; $display("FAIL store_rsp: wr=%b valid=%b err=%b rdata=%h want 0 10 0 0", MemWrite, rsp_valid, rsp_err, rsp_rdata);
    end
    tick();
    set_req(0, 1'b0, 64'd16, 64'd0);
    #3;
    tick();
    clr_req();
    tick();
    total++;
    if ({rsp_valid, rsp_rdata} !== {2'b01, 64'hDEADBEEF_00C0FFEE}) begin
      bad++; $display("FAIL store_readback: valid=%b rdata=%h want 01 deadbeef00c0ffee", rsp_valid, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g;
    logic [63:0] exp_a;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1'b0, 64'd0, 64'd0);
    set_req(1, 1'b0, 64'd8, 64'd0);
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (i % 2 == 0) ? 64'd0 : 64'd8;
      #3;
      total++;
      if (req_ready !== exp_g) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, exp_g); end
      tick();
      total++;
      if ({req_ready, MemRead, Mem_Addr} !== {2'b00, 1'b1, exp_a}) begin
        bad++; $display("FAIL rr_access%0d: ready=%b rd=%b addr=%0d want 00 1 %0d", i, req_ready, MemRead, Mem_Addr, exp_a);
      end
      tick();
      total++;
      if ({rsp_valid, rsp_rdata} !== {exp_g, exp_a + 64'd8 >> 3}) begin
        bad++; $display("FAIL rr_rsp%0d: valid=%b rdata=%h want %b %h", i, rsp_valid, rsp_rdata, exp_g, exp_a + 64'd8 >> 3);
      end
      if (i == 3) clr_req();
      tick();
    end
  endtask

  task automatic test_errors();
    logic [63:0] bad_addr [2] = '{64'd60, 64'hFFFF_FFFF_FFFF_FFF8};
    for (int i = 0; i < 2; i++) begin
      set_req(0, 1'b0, bad_addr[i], 64'd0);
      #3;
      total++;
      if ({req_ready, MemRead, MemWrite} !== {2'b01, 2'b00}) begin
        bad++; $display("FAIL err%0d_hs: ready=%b rd=%b wr=%b want 01 0 0", i, req_ready, MemRead, MemWrite);
      end
      tick();
      clr_req();
      total++;
      if ({rsp_valid, rsp_err, rsp_rdata, MemRead, MemWrite} !== {2'b01, 1'b1, 64'd0, 2'b00}) begin
        bad++; $display("FAIL err%0d_rsp: valid=%b err=%b rdata=%h rd=%b wr=%b", i, rsp_valid, rsp_err, rsp_rdata, MemRead, MemWrite);
      end
      tick();
    end
    set_req(0, 1'b0, 64'd12, 64'd0);
    #3;
    tick();
    clr_req();
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata, MemRead, MemWrite} !== {2'b01, 1'b1, 64'd0, 2'b00}) begin
      bad++; $display("FAIL misalign_rsp: valid=%b err=%b rdata=%h rd=%b wr=%b", rsp_valid, rsp_err, rsp_rdata, MemRead, MemWrite);
    end
    total++;
    if ({MemRead_na, Mem_Addr_na} !== {1'b1, 64'd12}) begin
      bad++; $display("FAIL noalign_strobe: rd=%b addr=%0d want 1 12", MemRead_na, Mem_Addr_na);
    end
    tick();
    total++;
    if ({rsp_valid_na, rsp_err_na, rsp_rdata_na} !== {2'b01, 1'b0, 64'h00C0FFEE_00000000}) begin
      bad++; $display("FAIL noalign_rsp: valid=%b err=%b rdata=%h want 01 0 00c0ffee00000000", rsp_valid_na, rsp_err_na, rsp_rdata_na);
    end
    total++;
    if (rsp_valid !== 2'b00) begin bad++; $display("FAIL misalign_single: valid=%b want 00", rsp_valid); end
    tick();
    set_req(0, 1'b0, 64'd56, 64'd0);
    #3;
    tick();
    clr_req();
    total++;
    if ({MemRead, Mem_Addr} !== {1'b1, 64'd56}) begin
      bad++; $display("FAIL edge56_strobe: rd=%b addr=%0d want 1 56", MemRead, Mem_Addr);
    end
    tick();
    total++;
    if ({rsp_valid, rsp_err, req_ready_na} !== {2'b01, 1'b0, 2'b00}) begin
      bad++; $display("FAIL edge56_rsp: valid=%b err=%b ready_na=%b want 01 0 00", rsp_valid, rsp_err, req_ready_na);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    set_req(0, 1'b1, 64'd0, 64'hFF);
    #3;
    tick();
    clr_req();
    total++;
    if (MemWrite !== 1'b1) begin bad++; $display("FAIL abort_pre: wr=%b want 1", MemWrite); end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({MemWrite, MemRead, Mem_Addr} !== 66'd0) begin
      bad++; $display("FAIL abort_drop: wr=%b rd=%b addr=%h want 0", MemWrite, MemRead, Mem_Addr);
    end
    tick();
    reset = 1'b0;
    total++;
    if (rsp_valid !== 2'b00) begin bad++; $display("FAIL abort_norsp0: valid=%b want 00", rsp_valid); end
    tick();
    total++;
    if (rsp_valid !== 2'b00) begin bad++; $display("FAIL abort_norsp1: valid=%b want 00", rsp_valid); end
    set_req(0, 1'b0, 64'd0, 64'd0);
    #3;
    tick();
    clr_req();
    tick();
    total++;
    if ({rsp_valid, rsp_rdata} !== {2'b01, 64'd1}) begin
      bad++; $display("FAIL abort_readback: valid=%b rdata=%h want 01 1", rsp_valid, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_drop_valid();
    set_req(1, 1'b0, 64'd8, 64'd0);
    #3;
    tick();
    clr_req();
    tick();
    set_req(0, 1'b0, 64'd0, 64'd0);
    #3;
    total++;
    if ({req_ready, rsp_valid} !== {2'b00, 2'b10}) begin
      bad++; $display("FAIL drop_inresp: ready=%b valid=%b want 00 10", req_ready, rsp_valid);
    end
    tick();
    clr_req();
    #3;
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("FAIL drop_ready: got %b want 00", req_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({rsp_valid, MemRead, MemWrite} !== 4'd0) begin
        bad++; $display("FAIL drop_idle%0d: valid=%b rd=%b wr=%b want 0", i, rsp_valid, MemRead, MemWrite);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    test_reset();
    test_load();
    test_store_load();
    test_round_robin();
    test_errors();
    test_reset_abort();
    test_drop_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
